alut_mem_arbiter22: RTL and testbench



---
 rtl/alut_mem_arbiter22.sv | 176 +++++++++++++++++
 tb/tb_alut_mem_arbiter22.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alut_mem_arbiter22.sv
// ALUT memory arbiter: shares the single-port 256x83 table between
// the address checker, the age checker and software, one access per cycle.
module alut_mem_arbiter22 #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 83,
  parameter int MAX_WAIT = 15
) (
  input  logic              pclk22,
  input  logic              p_reset22,
  input  logic              add_req22,
  input  logic              age_req22,
  input  logic              sw_req22,
  input  logic              add_lock22,
  input  logic              age_lock22,
  input  logic              sw_lock22,
  input  logic              add_write22,
  input  logic              age_write22,
  input  logic              sw_write22,
  input  logic [ADDR_W-1:0] add_addr22,
  input  logic [ADDR_W-1:0] age_addr22,
  input  logic [ADDR_W-1:0] sw_addr22,
  input  logic [DATA_W-1:0] add_wdata22,
  input  logic [DATA_W-1:0] age_wdata22,
  input  logic [DATA_W-1:0] sw_wdata22,
  output logic              add_gnt22,
  output logic              age_gnt22,
  output logic              sw_gnt22,
  output logic              add_rvalid22,
  output logic              age_rvalid22,
  output logic              sw_rvalid22,
  output logic [DATA_W-1:0] rdata22,
  output logic [ADDR_W-1:0] mem_addr22,
  output logic              mem_write22,
  output logic [DATA_W-1:0] mem_wdata22,
  input  logic [DATA_W-1:0] mem_rdata22,
  output logic              busy22
);

  localparam logic [1:0] NONE    = 2'd0;
  localparam logic [1:0] OWN_ADD = 2'd1;
  localparam logic [1:0] OWN_AGE = 2'd2;
  localparam logic [1:0] OWN_SW  = 2'd3;
  localparam logic [7:0] MW      = 8'(MAX_WAIT);

  logic [1:0]        owner;
  logic [1:0]        owner_nxt;
  logic              rr22;
  logic [7:0]        age_cnt;
  logic [7:0]        sw_cnt;
  logic [1:0]        rd_s1;
  logic [1:0]        rd_s2;
  logic              locked;
  logic              age_stv;
  logic              sw_stv;
  logic              any_gnt;
  logic              g_write;
  logic              g_lock;
  logic [1:0]        g_id;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  assign age_stv = age_req22 && (age_cnt == MW);
  assign sw_stv  = sw_req22 && (sw_cnt == MW);

  always_comb begin
    locked = 1'b0;
    case (owner)
      OWN_ADD: locked = add_lock22;
      OWN_AGE: locked = age_lock22;
      OWN_SW:  locked = sw_lock22;
      default: locked = 1'b0;
    endcase
  end

  // rr22 = 0 means age wins the next age/sw tie
  always_comb begin
    add_gnt22 = 1'b0;
    age_gnt22 = 1'b0;
    sw_gnt22  = 1'b0;
    if (!p_reset22) begin
      if (locked) begin
        add_gnt22 = (owner == OWN_ADD) && add_req22;
        age_gnt22 = (owner == OWN_AGE) && age_req22;
        sw_gnt22  = (owner == OWN_SW) && sw_req22;
      end else if (age_stv && sw_stv) begin
        age_gnt22 = !rr22;
        sw_gnt22  = rr22;
      end else if (age_stv) begin
        age_gnt22 = 1'b1;
      end else if (sw_stv) begin
        sw_gnt22 = 1'b1;
      end else if (add_req22) begin
        add_gnt22 = 1'b1;
      end else if (age_req22 && sw_req22) begin
        age_gnt22 = !rr22;
        sw_gnt22  = rr22;
      end else begin
        age_gnt22 = age_req22;
        sw_gnt22  = sw_req22;
      end
    end
  end

  always_comb begin
    any_gnt = add_gnt22 | age_gnt22 | sw_gnt22;
    g_write = 1'b0;
    g_lock  = 1'b0;
    g_id    = NONE;
    g_addr  = add_addr22;
    g_wdata = add_wdata22;
    unique case (1'b1)
      add_gnt22: begin
        g_write = add_write22;
        g_lock  = add_lock22;
        g_id    = OWN_ADD;
      end
      age_gnt22: begin
        g_write = age_write22;
        g_lock  = age_lock22;
        g_id    = OWN_AGE;
        g_addr  = age_addr22;
        g_wdata = age_wdata22;
      end
      sw_gnt22: begin
        g_write = sw_write22;
        g_lock  = sw_lock22;
        g_id    = OWN_SW;
        g_addr  = sw_addr22;
        g_wdata = sw_wdata22;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_nxt = NONE;
    if (any_gnt && g_lock) owner_nxt = g_id;
    else if (locked)       owner_nxt = owner;
  end

  always_ff @(posedge pclk22) begin
    if (p_reset22) begin
      owner       <= NONE;
      rr22        <= 1'b0;
      age_cnt     <= 8'd0;
      sw_cnt      <= 8'd0;
      rd_s1       <= NONE;
      rd_s2       <= NONE;
      mem_addr22  <= '0;
      mem_write22 <= 1'b0;
      mem_wdata22 <= '0;
    end else begin
      owner       <= owner_nxt;
      mem_write22 <= any_gnt && g_write;
      if (any_gnt) begin
        mem_addr22  <= g_addr;
        mem_wdata22 <= g_wdata;
      end
      rd_s1 <= (any_gnt && !g_write) ? g_id : NONE;
      rd_s2 <= rd_s1;
      if (age_gnt22)     rr22 <= 1'b1;
      else if (sw_gnt22) rr22 <= 1'b0;
      if (!age_req22 || age_gnt22) age_cnt <= 8'd0;
      else if (age_cnt != MW)      age_cnt <= age_cnt + 8'd1;
      if (!sw_req22 || sw_gnt22) sw_cnt <= 8'd0;
      else if (sw_cnt != MW)     sw_cnt <= sw_cnt + 8'd1;
    end
  end

  assign add_rvalid22 = (rd_s2 == OWN_ADD);
  assign age_rvalid22 = (rd_s2 == OWN_AGE);
  assign sw_rvalid22  = (rd_s2 == OWN_SW);
  assign rdata22      = mem_rdata22;
  assign busy22       = (owner != NONE) || (rd_s1 != NONE) || (rd_s2 != NONE);

endmodule

// File: tb/tb_alut_mem_arbiter22.sv
// Directed bench for alut_mem_arbiter22 with a write-first
// synchronous RAM model attached to the memory port.
module tb_alut_mem_arbiter22;

  logic        pclk22 = 1'b0;
  logic        p_reset22 = 1'b1;
  logic        add_req22, age_req22, sw_req22;
  logic        add_lock22, age_lock22, sw_lock22;
  logic        add_write22, age_write22, sw_write22;
  logic [7:0]  add_addr22, age_addr22, sw_addr22;
  logic [82:0] add_wdata22, age_wdata22, sw_wdata22;
  logic        add_gnt22, age_gnt22, sw_gnt22;
  logic        add_rvalid22, age_rvalid22, sw_rvalid22;
  logic [82:0] rdata22;
  logic [7:0]  mem_addr22;
  logic        mem_write22;
  logic [82:0] mem_wdata22;
  logic [82:0] mem_rdata22;
  logic        busy22;

  logic [82:0] ram [256];
  int checks = 0;
  int errors = 0;

  localparam logic [82:0] V3C = 83'h4_0000_0001_0000_0000_ABCD;
  localparam logic [82:0] VWR = 83'h5_1234_5678_9ABC_DEF0_1357;
  localparam logic [82:0] VBB = 83'h2_AAAA_5555_0F0F_F0F0_3C3C;

  alut_mem_arbiter22 #(.ADDR_W(8), .DATA_W(83), .MAX_WAIT(15)) dut (
    .pclk22(pclk22), .p_reset22(p_reset22),
    .add_req22(add_req22), .age_req22(age_req22), .sw_req22(sw_req22),
    .add_lock22(add_lock22), .age_lock22(age_lock22), .sw_lock22(sw_lock22),
    .add_write22(add_write22), .age_write22(age_write22),
    .sw_write22(sw_write22),
    .add_addr22(add_addr22), .age_addr22(age_addr22), .sw_addr22(sw_addr22),
    .add_wdata22(add_wdata22), .age_wdata22(age_wdata22),
    .sw_wdata22(sw_wdata22),
    .add_gnt22(add_gnt22), .age_gnt22(age_gnt22), .sw_gnt22(sw_gnt22),
    .add_rvalid22(add_rvalid22), .age_rvalid22(age_rvalid22),
    .sw_rvalid22(sw_rvalid22),
    .rdata22(rdata22), .mem_addr22(mem_addr22), .mem_write22(mem_write22),
    .mem_wdata22(mem_wdata22), .mem_rdata22(mem_rdata22), .busy22(busy22)
  );

  always #5 pclk22 = ~pclk22;

  always @(posedge pclk22) begin
    if (mem_write22) ram[mem_addr22] <= mem_wdata22;
    mem_rdata22 <= mem_write22 ? mem_wdata22 : ram[mem_addr22];
  end

  task automatic tick();
    @(posedge pclk22);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    {add_req22, age_req22, sw_req22} = '0;
    {add_lock22, age_lock22, sw_lock22} = '0;
    {add_write22, age_write22, sw_write22} = '0;
    add_addr22 = '0; age_addr22 = '0; sw_addr22 = '0;
    add_wdata22 = '0; age_wdata22 = '0; sw_wdata22 = '0;
  endtask

  task automatic do_reset();
    tick();
    clear_in();
    p_reset22 = 1'b1;
    tick();
    tick();
    p_reset22 = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    p_reset22 = 1'b1;
    add_req22 = 1; age_req22 = 1; sw_req22 = 1;
    tick();
    tick();
    settle();
    checks++;
    if ({add_gnt22, age_gnt22, sw_gnt22} !== 3'b000) begin
      errors++;
      $display("FAIL rst_gnt: got %b exp 000",
               {add_gnt22, age_gnt22, sw_gnt22});
    end
    checks++;
    if (mem_write22 !== 1'b0 || mem_addr22 !== 8'h00) begin
      errors++;
      $display("FAIL rst_mem: got wr=%b addr=%h exp 0/00",
               mem_write22, mem_addr22);
    end
    checks++;
    if (busy22 !== 1'b0 || mem_wdata22 !== 83'h0) begin
      errors++;
      $display("FAIL rst_busy: got busy=%b wdata=%h exp 0/0",
               busy22, mem_wdata22);
    end
    tick();
    p_reset22 = 1'b0;
    settle();
    checks++;
    if ({add_gnt22, age_gnt22, sw_gnt22} !== 3'b100) begin
      errors++;
      $display("FAIL rst_first: got %b exp 100",
               {add_gnt22, age_gnt22, sw_gnt22});
    end
    tick();
    clear_in();
  endtask

  task automatic test_single_read();
    do_reset();
    ram[8'h3C] = V3C;
    sw_req22 = 1; sw_addr22 = 8'h3C;
    settle();
    checks++;
    if (sw_gnt22 !== 1'b1 || busy22 !== 1'b0) begin
      errors++;
      $display("FAIL rd_gnt: got gnt=%b busy=%b exp 1/0", sw_gnt22, busy22);
    end
    tick();
    sw_req22 = 0;
    settle();
    checks++;
    if (mem_addr22 !== 8'h3C || mem_write22 !== 1'b0 || busy22 !== 1'b1) begin
      errors++;
      $display("FAIL rd_addr: got addr=%h wr=%b busy=%b exp 3c/0/1",
               mem_addr22, mem_write22, busy22);
    end
    checks++;
    if (sw_rvalid22 !== 1'b0) begin
      errors++;
      $display("FAIL rd_early: got rvalid=%b exp 0", sw_rvalid22);
    end
    tick();
    checks++;
    if (sw_rvalid22 !== 1'b1 || rdata22 !== V3C || busy22 !== 1'b1) begin
      errors++;
      $display("FAIL rd_data: got v=%b d=%h busy=%b exp 1/%h/1",
               sw_rvalid22, rdata22, busy22, V3C);
    end
    checks++;
    if (add_rvalid22 !== 1'b0 || age_rvalid22 !== 1'b0) begin
      errors++;
      $display("FAIL rd_other: got add=%b age=%b exp 0/0",
               add_rvalid22, age_rvalid22);
    end
    tick();
    checks++;
    if (sw_rvalid22 !== 1'b0 || busy22 !== 1'b0) begin
      errors++;
      $display("FAIL rd_end: got v=%b busy=%b exp 0/0", sw_rvalid22, busy22);
    end
  endtask

  task automatic test_lock();
    int wr_cnt;
    do_reset();
    ram[8'h12] = 83'h1_0000_0000_0000_0000_0042;
    wr_cnt = 0;
    age_req22 = 1; age_addr22 = 8'h77;
    add_req22 = 1; add_lock22 = 1; add_addr22 = 8'h12;
    settle();
    checks++;
    if (add_gnt22 !== 1'b1 || age_gnt22 !== 1'b0) begin
      errors++;
      $display("FAIL lk_rd: got add=%b age=%b exp 1/0", add_gnt22, age_gnt22);
    end
    tick();
    add_write22 = 1; add_wdata22 = VWR;
    settle();
    wr_cnt += int'(mem_write22);
    checks++;
    if (add_gnt22 !== 1'b1 || age_gnt22 !== 1'b0 || busy22 !== 1'b1) begin
      errors++;
      $display("FAIL lk_wr: got add=%b age=%b busy=%b exp 1/0/1",
               add_gnt22, age_gnt22, busy22);
    end
    tick();
    add_req22 = 0; add_write22 = 0;
    settle();
    wr_cnt += int'(mem_write22);
    checks++;
    if (age_gnt22 !== 1'b0 || mem_write22 !== 1'b1 || add_rvalid22 !== 1'b1) begin
      errors++;
      $display("FAIL lk_hold: got age=%b wr=%b rv=%b exp 0/1/1",
               age_gnt22, mem_write22, add_rvalid22);
    end
    tick();
    add_lock22 = 0;
    settle();
    wr_cnt += int'(mem_write22);
    checks++;
    if (age_gnt22 !== 1'b1) begin
      errors++;
      $display("FAIL lk_rel: got age=%b exp 1", age_gnt22);
    end
    tick();
    age_req22 = 0;
    settle();
    wr_cnt += int'(mem_write22);
    checks++;
    if (wr_cnt !== 1) begin
      errors++;
      $display("FAIL lk_wrcnt: got %0d write cycles exp 1", wr_cnt);
    end
    tick();
    sw_req22 = 1; sw_addr22 = 8'h12;
    tick();
    sw_req22 = 0;
    tick();
    checks++;
    if (sw_rvalid22 !== 1'b1 || rdata22 !== VWR) begin
      errors++;
      $display("FAIL lk_readback: got v=%b d=%h exp 1/%h",
               sw_rvalid22, rdata22, VWR);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq;
    do_reset();
    seq = '0;
    age_req22 = 1; sw_req22 = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      seq[i] = sw_gnt22;
      checks++;
      if ((age_gnt22 ^ sw_gnt22) !== 1'b1 || add_gnt22 !== 1'b0) begin
        errors++;
        $display("FAIL rr_one: cyc %0d got age=%b sw=%b exp exactly one",
                 i, age_gnt22, sw_gnt22);
      end
      tick();
    end
    checks++;
    if (seq !== 4'b1010) begin
      errors++;
      $display("FAIL rr_seq: got sw pattern %b exp 1010", seq);
    end
    clear_in();
  endtask

  task automatic test_starvation();
    int sw_at;
    int sw_at2;
    do_reset();
    sw_at = 0; sw_at2 = 0;
    add_req22 = 1; sw_req22 = 1;
    for (int c = 1; c <= 34; c++) begin
      settle();
      if (sw_gnt22 === 1'b1 && add_gnt22 === 1'b0) begin
        if (sw_at == 0) sw_at = c;
        else if (sw_at2 == 0) sw_at2 = c;
      end
      if (c == 17) begin
        checks++;
        if (add_gnt22 !== 1'b1 || sw_gnt22 !== 1'b0) begin
          errors++;
          $display("FAIL stv_regrant: got add=%b sw=%b exp 1/0",
                   add_gnt22, sw_gnt22);
        end
      end
      tick();
    end
    clear_in();
    checks++;
    if (sw_at !== 16) begin
      errors++;
      $display("FAIL stv_first: got sw grant cycle %0d exp 16", sw_at);
    end
    checks++;
    if (sw_at2 !== 32) begin
      errors++;
      $display("FAIL stv_second: got sw grant cycle %0d exp 32", sw_at2);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sw_req22 = 1; sw_write22 = 1; sw_addr22 = 8'h05; sw_wdata22 = VBB;
    tick();
    sw_write22 = 0;
    settle();
    checks++;
    if (sw_gnt22 !== 1'b1 || mem_write22 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wr: got gnt=%b wr=%b exp 1/1", sw_gnt22, mem_write22);
    end
    tick();
    sw_req22 = 0;
    settle();
    checks++;
    if (mem_write22 !== 1'b0 || mem_addr22 !== 8'h05) begin
      errors++;
      $display("FAIL b2b_rd: got wr=%b addr=%h exp 0/05",
               mem_write22, mem_addr22);
    end
    tick();
    checks++;
    if (sw_rvalid22 !== 1'b1 || rdata22 !== VBB) begin
      errors++;
      $display("FAIL b2b_raw: got v=%b d=%h exp 1/%h",
               sw_rvalid22, rdata22, VBB);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    sw_req22 = 1; sw_addr22 = 8'h3C;
    settle();
    checks++;
    if (sw_gnt22 !== 1'b1) begin
      errors++;
      $display("FAIL mr_gnt: got %b exp 1", sw_gnt22);
    end
    tick();
    sw_req22 = 0;
    p_reset22 = 1;
    tick();
    p_reset22 = 0;
    settle();
    checks++;
    if (sw_rvalid22 !== 1'b0 || busy22 !== 1'b0) begin
      errors++;
      $display("FAIL mr_flush: got v=%b busy=%b exp 0/0", sw_rvalid22, busy22);
    end
    tick();
    checks++;
    if (sw_rvalid22 !== 1'b0) begin
      errors++;
      $display("FAIL mr_late: got v=%b exp 0", sw_rvalid22);
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_single_read();
    test_lock();
    test_round_robin();
    test_starvation();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish exp finish before 200000");
    $fatal(1);
  end

endmodule
